// File: rtl/ising_config_pkg.sv
// Shared configuration for the Ising fabric: GPIO configuration-bus field
// placement, write-pacing defaults and the GPIO transmitter state type.
package ising_config;

  localparam int gpio_bus_width  = 32;
  localparam int gpio_addr_start = 0;
  localparam int gpio_addr_end   = 15;
  localparam int gpio_addr_width = gpio_addr_end - gpio_addr_start + 1;
  localparam int gpio_data_start = 16;
  localparam int gpio_data_end   = 23;
  localparam int gpio_data_width = gpio_data_end - gpio_data_start + 1;
  localparam int gpio_w_clk_bit  = 24;

  localparam int GPIO_SETUP_CYC  = 2;
  localparam int GPIO_STROBE_CYC = 4;
  localparam int GPIO_HOLD_CYC   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } gpio_tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gpio_wr_fifo.sv
// Request queue for the GPIO write master: power-of-two deep synchronous FIFO
// with registered empty/full flags and first-word-fall-through read data.
module gpio_wr_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, full_q;
  logic                  do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == (DEPTH_LOG2 + 1)'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/gpio_write_master.sv
// Fabric-side GPIO configuration writer: drains queued (addr, data) pairs onto
// the GPIO word with paced setup / strobe / hold windows.
module gpio_write_master
  import ising_config::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int SETUP_CYC       = GPIO_SETUP_CYC,
  parameter int STROBE_CYC      = GPIO_STROBE_CYC,
  parameter int HOLD_CYC        = GPIO_HOLD_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [gpio_addr_width-1:0] wr_addr,
  input  logic [gpio_data_width-1:0] wr_data,
  output logic [gpio_bus_width-1:0]  gpio_out,
  output logic                       busy,
  output logic [15:0]                writes_done,
  output gpio_tx_state_t             state_dbg_o
);

  localparam int CNT_W  = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC));
  localparam int FIFO_W = gpio_data_width + gpio_addr_width;
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  // Handshake: a request is taken on a rising edge where wr_valid && wr_ready;
  // wr_ready is the registered !full, so a same-cycle pop never frees a slot.
  gpio_tx_state_t             state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [gpio_addr_width-1:0] addr_q;
  logic [gpio_data_width-1:0] data_q;
  logic                       strobe_q;
  logic [15:0]                done_q;

  logic              fifo_empty, fifo_full, load;
  logic [FIFO_W-1:0] fifo_rdata;

  gpio_wr_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2),
    .WIDTH     (FIFO_W)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (wr_valid),
    .wdata_i({wr_data, wr_addr}),
    .pop_i  (load),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  // A new word is loaded from IDLE or straight out of the last HOLD cycle.
  assign load = !fifo_empty &&
                ((state_q == IDLE) || ((state_q == HOLD) && (cnt_q == HOLD_LAST)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= '0;
    end else begin
      if (load) {data_q, addr_q} <= fifo_rdata;
      case (state_q)
        IDLE: begin
          if (load) begin
            cnt_q   <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q    <= '0;
            strobe_q <= 1'b1;
            state_q  <= STROBE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STROBE: begin
          if (cnt_q == STROBE_LAST) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            done_q   <= done_q + 16'd1;
            state_q  <= HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            state_q <= load ? SETUP : IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q    <= '0;
          strobe_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    gpio_out = '0;
    gpio_out[gpio_addr_end:gpio_addr_start] = addr_q;
    gpio_out[gpio_data_end:gpio_data_start] = data_q;
    gpio_out[gpio_w_clk_bit]                = strobe_q;
  end

  assign wr_ready    = !fifo_full;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign writes_done = done_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_gpio_write_master.sv
// Bench for gpio_write_master: a default-timed and a fastest-timed instance
// share one stimulus stream and are scored against a transaction-level model.
module tb_gpio_write_master;
  import ising_config::*;

  localparam int DEPTH = 16;
  localparam int S0 = 2, T0 = 4, H0 = 2;
  localparam int S1 = 1, T1 = 3, H1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rdy  [2];
  logic [31:0] gpio [2];
  logic        busy [2];
  logic [15:0] wd   [2];
  gpio_tx_state_t st [2];

  gpio_write_master #(.FIFO_DEPTH_LOG2(4), .SETUP_CYC(S0), .STROBE_CYC(T0), .HOLD_CYC(H0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy[0]), .wr_addr(wr_addr),
    .wr_data(wr_data), .gpio_out(gpio[0]), .busy(busy[0]), .writes_done(wd[0]),
    .state_dbg_o(st[0])
  );

  gpio_write_master #(.FIFO_DEPTH_LOG2(4), .SETUP_CYC(S1), .STROBE_CYC(T1), .HOLD_CYC(H1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy[1]), .wr_addr(wr_addr),
    .wr_data(wr_data), .gpio_out(gpio[1]), .busy(busy[1]), .writes_done(wd[1]),
    .state_dbg_o(st[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int s_cyc(input int k); return (k == 0) ? S0 : S1; endfunction
  function automatic int t_cyc(input int k); return (k == 0) ? T0 : T1; endfunction
  function automatic int p_cyc(input int k); return (k == 0) ? S0 + T0 + H0 : S1 + T1 + H1; endfunction

  // Reference model: request queue contents plus the time of the last load.
  logic [23:0] mq0[$], mq1[$];
  logic [23:0] exp_q0[$], exp_q1[$];
  int          rise0[$], rise1[$];
  int          e;
  int          next_load [2];
  int          load_edge [2];
  int          loads     [2];
  logic [23:0] cur_word  [2];
  logic [15:0] exp_done  [2];
  logic [31:0] exp_gpio  [2];
  bit          exp_busy  [2];
  bit          exp_rdy   [2];

  function automatic int mq_size(input int k); return (k == 0) ? mq0.size() : mq1.size(); endfunction
  function automatic logic [23:0] mq_pop(input int k);
    if (k == 0) return mq0.pop_front();
    return mq1.pop_front();
  endfunction
  function automatic void mq_push(input int k, input logic [23:0] w);
    if (k == 0) begin mq0.push_back(w); exp_q0.push_back(w); end
    else begin mq1.push_back(w); exp_q1.push_back(w); end
  endfunction
  function automatic int sb_size(input int k); return (k == 0) ? exp_q0.size() : exp_q1.size(); endfunction
  function automatic logic [23:0] sb_pop(input int k);
    if (k == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction
  function automatic void rise_push(input int k, input int c);
    if (k == 0) rise0.push_back(c);
    else rise1.push_back(c);
  endfunction

  task automatic reset_model();
    mq0.delete(); mq1.delete(); exp_q0.delete(); exp_q1.delete();
    for (int k = 0; k < 2; k++) begin
      next_load[k] = 0; load_edge[k] = -1; cur_word[k] = '0; exp_done[k] = '0;
      exp_gpio[k] = '0; exp_busy[k] = 1'b0; exp_rdy[k] = 1'b1;
    end
  endtask

  task automatic model_edge(input bit v, input logic [23:0] w);
    for (int k = 0; k < 2; k++) begin
      int sz;
      bit acc, pop, stb;
      sz  = mq_size(k);
      acc = v && (sz < DEPTH);
      pop = (sz > 0) && (e >= next_load[k]);
      if (load_edge[k] >= 0 && e == load_edge[k] + s_cyc(k) + t_cyc(k)) exp_done[k]++;
      if (pop) begin
        cur_word[k] = mq_pop(k);
        load_edge[k] = e;
        next_load[k] = e + p_cyc(k);
        loads[k]++;
      end
      if (acc) mq_push(k, w);
      stb = (load_edge[k] >= 0) && (e >= load_edge[k] + s_cyc(k)) &&
            (e < load_edge[k] + s_cyc(k) + t_cyc(k));
      exp_gpio[k] = {7'b0, stb, cur_word[k]};
      exp_busy[k] = (mq_size(k) > 0) || ((load_edge[k] >= 0) && (e < next_load[k]));
      exp_rdy[k]  = mq_size(k) < DEPTH;
    end
    e++;
  endtask

  task automatic step(input bit v, input logic [23:0] w);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("gpio_out%0d", k), gpio[k], exp_gpio[k]);
      check($sformatf("busy%0d", k), {31'b0, busy[k]}, {31'b0, exp_busy[k]});
      check($sformatf("wr_ready%0d", k), {31'b0, rdy[k]}, {31'b0, exp_rdy[k]});
      check($sformatf("writes_done%0d", k), {16'b0, wd[k]}, {16'b0, exp_done[k]});
    end
    wr_valid = v;
    wr_addr  = w[15:0];
    wr_data  = w[23:16];
    model_edge(v, w);
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_busy[0] || exp_busy[1]) && n < 400) begin
      step(1'b0, 24'h0);
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles", n);
    end
    repeat (4) step(1'b0, 24'h0);
    for (int k = 0; k < 2; k++) check($sformatf("fsm_idle%0d", k), 32'(st[k]), 32'(IDLE));
  endtask

  // Decoder model: 2-flop synchronizer on the strobe, capture on its rising edge.
  bit          s1 [2], s2 [2], s3 [2], prev_hi [2];
  int          hi_len [2];
  logic [23:0] prev_word [2];
  int          cyc = 0;
  bit          rec_en = 1'b0;

  always @(negedge clk) begin : monitor
    logic [23:0] want;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        s1[k] = 0; s2[k] = 0; s3[k] = 0; prev_hi[k] = 0; hi_len[k] = 0;
      end else begin
        if (gpio[k][24]) begin
          if (prev_hi[k]) check($sformatf("stable_under_strobe%0d", k), {8'h0, gpio[k][23:0]}, {8'h0, prev_word[k]});
          else if (rec_en) rise_push(k, cyc);
          hi_len[k]++;
        end else if (prev_hi[k]) begin
          check($sformatf("strobe_width%0d", k), hi_len[k], t_cyc(k));
          hi_len[k] = 0;
        end
        prev_hi[k]   = gpio[k][24];
        prev_word[k] = gpio[k][23:0];
        s3[k] = s2[k]; s2[k] = s1[k]; s1[k] = gpio[k][24];
        if (s2[k] && !s3[k]) begin
          if (sb_size(k) == 0) begin
            check($sformatf("unexpected_capture%0d", k), {8'h0, gpio[k][23:0]}, 32'hFFFF_FFFF);
          end else begin
            want = sb_pop(k);
            check($sformatf("decoder_capture%0d", k), {8'h0, gpio[k][23:0]}, {8'h0, want});
          end
        end
      end
    end
  end

  initial begin : driver
    int n, base;
    logic [15:0] a;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rst = 1'b0; e = 0;
    loads[0] = 0; loads[1] = 0;
    reset_model();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_gpio%0d", k), gpio[k], 32'h0);
      check($sformatf("rst_done%0d", k), {16'b0, wd[k]}, 32'h0);
      check($sformatf("rst_busy%0d", k), {31'b0, busy[k]}, 32'h0);
      check($sformatf("rst_ready%0d", k), {31'b0, rdy[k]}, 32'h1);
    end
    #2 rst = 1'b1;

    // Single write at default timing.
    step(1'b1, {8'hA5, 16'h000C});
    drain();
    check("single_done", {16'b0, wd[0]}, 32'h1);
    check("single_word", gpio[0], 32'h00A5000C);

    // Back-to-back burst that overfills the default instance.
    rec_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 16'(i);
      step(1'b1, {a[7:0] + 8'h40, a});
    end
    drain();
    rec_en = 1'b0;
    check("burst_strobes0", rise0.size(), 19);
    check("burst_strobes1", rise1.size(), 20);
    for (int i = 1; i < rise0.size(); i++) check("burst_period0", rise0[i] - rise0[i-1], p_cyc(0));
    for (int i = 1; i < rise1.size(); i++) check("burst_period1", rise1[i] - rise1[i-1], p_cyc(1));

    // Random traffic.
    for (int i = 0; i < 250; i++)
      step($urandom_range(0, 99) < 35, 24'($urandom));
    drain();

    // Counter wrap from 16'hFFFF.
    @(negedge clk);
    force u_dut0.done_q = 16'hFFFF;
    #1 release u_dut0.done_q;
    exp_done[0] = 16'hFFFF;
    step(1'b1, {8'h3C, 16'h1234});
    drain();
    check("wrap_done", {16'b0, wd[0]}, 32'h0);

    // Reset while the third of five queued writes is strobing.
    base = loads[0];
    for (int i = 0; i < 5; i++) step(1'b1, 24'($urandom));
    n = 0;
    while (!(loads[0] == base + 3 && exp_gpio[0][24]) && n < 200) begin
      step(1'b0, 24'h0);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL reset_point_timeout: third strobe not reached after %0d cycles", n);
    end
    #1 check("pre_rst_strobe", {31'b0, gpio[0][24]}, 32'h1);
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrst_gpio%0d", k), gpio[k], 32'h0);
      check($sformatf("midrst_done%0d", k), {16'b0, wd[k]}, 32'h0);
      check($sformatf("midrst_busy%0d", k), {31'b0, busy[k]}, 32'h0);
      check($sformatf("midrst_ready%0d", k), {31'b0, rdy[k]}, 32'h1);
    end
    reset_model();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (30) step(1'b0, 24'h0);
    drain();

    check("sb_empty0", exp_q0.size(), 0);
    check("sb_empty1", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
